instr_fetch: RTL and testbench

Instruction fetch stage sitting between the PC controller and decode. It takes the current `pc_value` and performs a single-outstanding read from instruction memory over a req/ack handshake. It presents the fetched word to decode with valid/ready, and on acceptance pulses `pc_en` so the PC controller advances. A `flush` input discards the in-flight fetch when the pipeline redirects.

---
 rtl/instr_fetch.sv | 125 ++++++++++++
 tb/tb_instr_fetch.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_fetch.sv
// Instruction fetch stage: single-outstanding memory read from the current PC,
// presents the fetched word to decode with valid/ready and pulses pc_en once
// decode has accepted it. A flush abandons the fetch without advancing the PC.
module instr_fetch #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DWIDTH-1:0] pc_value,
  output logic              pc_en,
  output logic              mem_req,
  output logic [AWIDTH-1:0] mem_addr,
  input  logic              mem_ack,
  input  logic [DWIDTH-1:0] mem_rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DWIDTH-1:0] instr_out,
  output logic [DWIDTH-1:0] instr_pc,
  output logic              instr_misaligned,
  input  logic              flush
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2,
    ADV  = 2'd3
  } state_t;

  state_t            state_reg, state_next;
  logic [AWIDTH-1:0] mem_addr_reg, mem_addr_next;
  logic [DWIDTH-1:0] instr_out_reg, instr_out_next;
  logic [DWIDTH-1:0] instr_pc_reg, instr_pc_next;
  logic              misaligned_reg, misaligned_next;
  // Set when a flush hits an unanswered request; the eventual data is thrown away.
  logic              drop_reg, drop_next;

  // State and datapath registers, cleared asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      mem_addr_reg   <= '0;
      instr_out_reg  <= '0;
      instr_pc_reg   <= '0;
      misaligned_reg <= 1'b0;
      drop_reg       <= 1'b0;
    end else begin
      state_reg      <= state_next;
      mem_addr_reg   <= mem_addr_next;
      instr_out_reg  <= instr_out_next;
      instr_pc_reg   <= instr_pc_next;
      misaligned_reg <= misaligned_next;
      drop_reg       <= drop_next;
    end
  end

  // Next-state and datapath update decisions.
  always_comb begin
    state_next      = state_reg;
    mem_addr_next   = mem_addr_reg;
    instr_out_next  = instr_out_reg;
    instr_pc_next   = instr_pc_reg;
    misaligned_next = misaligned_reg;
    drop_next       = drop_reg;

    case (state_reg)
      IDLE: begin
        // Address is latched every idle cycle so it is stable throughout REQ.
        mem_addr_next = pc_value[AWIDTH-1:0];
        if (!flush) begin
          if (pc_value[1:0] != 2'b00) begin
            // Misaligned PC: report it to decode without touching memory.
            state_next      = HOLD;
            misaligned_next = 1'b1;
            instr_pc_next   = pc_value;
            instr_out_next  = '0;
          end else begin
            state_next = REQ;
          end
        end
      end
      REQ: begin
        if (mem_ack) begin
          drop_next = 1'b0;
          if (drop_reg || flush) begin
            state_next = IDLE;
          end else begin
            state_next      = HOLD;
            instr_out_next  = mem_rdata;
            instr_pc_next   = DWIDTH'(mem_addr_reg);
            misaligned_next = 1'b0;
          end
        end else if (flush) begin
          // Request must stay up until answered; remember to discard it.
          drop_next = 1'b1;
        end
      end
      HOLD: begin
        // Flush takes priority over acceptance so the PC is not advanced.
        if (flush) begin
          state_next = IDLE;
        end else if (instr_ready) begin
          state_next = ADV;
        end
      end
      ADV: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Handshake outputs decode straight from the state register.
  assign mem_req          = (state_reg == REQ);
  assign instr_valid      = (state_reg == HOLD);
  assign pc_en            = (state_reg == ADV);
  assign mem_addr         = mem_addr_reg;
  assign instr_out        = instr_out_reg;
  assign instr_pc         = instr_pc_reg;
  assign instr_misaligned = misaligned_reg;

endmodule

// File: tb/tb_instr_fetch.sv
// Testbench for instr_fetch: directed scenarios followed by randomized traffic,
// all checked cycle by cycle against a transaction-level reference model.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] pc = 32'h0;
  logic        pc_en;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        ack = 1'b0;
  logic [31:0] rdata = 32'h0;
  logic        instr_valid;
  logic        ready = 1'b0;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        instr_misaligned;
  logic        flush = 1'b0;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: what the fetch unit is doing right now, as activities.
  bit          e_fetching;   // a memory read is outstanding
  bit          e_presenting; // an instruction is offered to decode
  bit          e_advancing;  // PC advance pulse this cycle
  bit          e_discard;    // outstanding read was flushed
  logic [31:0] e_addr, e_out, e_pc;
  bit          e_mis;

  instr_fetch #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk              (clk),
    .reset            (reset),
    .pc_value         (pc),
    .pc_en            (pc_en),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (ack),
    .mem_rdata        (rdata),
    .instr_valid      (instr_valid),
    .instr_ready      (ready),
    .instr_out        (instr_out),
    .instr_pc         (instr_pc),
    .instr_misaligned (instr_misaligned),
    .flush            (flush)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic void model_reset();
    e_fetching = 0; e_presenting = 0; e_advancing = 0; e_discard = 0;
    e_addr = 0; e_out = 0; e_pc = 0; e_mis = 0;
  endfunction

  // Advance the model by one clock using the inputs currently applied.
  function automatic void model_step();
    if (e_advancing) begin
      e_advancing = 0;
    end else if (e_presenting) begin
      if (flush) e_presenting = 0;
      else if (ready) begin e_presenting = 0; e_advancing = 1; end
    end else if (e_fetching) begin
      if (ack) begin
        e_fetching = 0;
        if (e_discard || flush) e_discard = 0;
        else begin
          e_presenting = 1; e_out = rdata; e_pc = e_addr; e_mis = 0;
        end
      end else if (flush) begin
        e_discard = 1;
      end
    end else begin
      e_addr = pc;
      if (!flush) begin
        if (pc % 4 != 0) begin
          e_presenting = 1; e_mis = 1; e_pc = pc; e_out = 0;
        end else begin
          e_fetching = 1;
        end
      end
    end
  endfunction

  task automatic compare_all();
    check("mem_req", mem_req, e_fetching);
    check("mem_addr", mem_addr, e_addr);
    check("instr_valid", instr_valid, e_presenting);
    check("pc_en", pc_en, e_advancing);
    if (e_presenting) begin
      check("instr_out", instr_out, e_out);
      check("instr_pc", instr_pc, e_pc);
      check("instr_misaligned", instr_misaligned, e_mis);
    end
  endtask

  // One clock: model follows the inputs, PC controller advances after pc_en.
  task automatic cycle();
    bit was_adv;
    was_adv = e_advancing;
    model_step();
    @(posedge clk);
    #1;
    if (was_adv) pc = pc + 32'd4;
    compare_all();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_mem_req"}, mem_req, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_pc_en"}, pc_en, 0);
    check({tag, "_instr_valid"}, instr_valid, 0);
    check({tag, "_instr_out"}, instr_out, 0);
    check({tag, "_instr_pc"}, instr_pc, 0);
    check({tag, "_instr_misaligned"}, instr_misaligned, 0);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    flush = 1'b0;
    ready = 1'b0;
    #1;
    model_reset();
    check_reset_values("rst");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    // Reset and first fetch
    pc = 32'h0;
    do_reset();
    compare_all();
    cycle();                                  // IDLE -> REQ
    check("first_req", mem_req, 1);
    check("first_addr", mem_addr, 32'h0);
    ack = 1; rdata = 32'h0050_0093; ready = 1;
    cycle();                                  // ack -> HOLD
    ack = 0;
    check("first_valid", instr_valid, 1);
    check("first_out", instr_out, 32'h0050_0093);
    check("first_pc", instr_pc, 32'h0);
    cycle();                                  // ADV
    check("first_pc_en", pc_en, 1);
    cycle();                                  // back to IDLE
    check("first_pc_en_single", pc_en, 0);
    ready = 0;

    // Memory wait states at 0x40
    pc = 32'h40;
    cycle();
    for (int i = 0; i < 3; i++) begin
      rdata = 32'hBAD0_0000 + i;              // not acked, must not be captured
      cycle();
      check("ws_req", mem_req, 1);
      check("ws_addr", mem_addr, 32'h40);
      check("ws_valid", instr_valid, 0);
    end
    ack = 1; rdata = 32'h1234_5678;
    cycle();
    ack = 0;
    check("ws_req_drop", mem_req, 0);
    check("ws_out", instr_out, 32'h1234_5678);
    check("ws_pc", instr_pc, 32'h40);

    // Decode backpressure
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("bp_valid", instr_valid, 1);
      check("bp_out", instr_out, 32'h1234_5678);
      check("bp_no_pc_en", pc_en, 0);
    end
    ready = 1;
    cycle();
    check("bp_pc_en", pc_en, 1);
    ready = 0;
    cycle();
    check("bp_pc_en_once", pc_en, 0);
    check("bp_pc_advanced", pc, 32'h44);

    // Flush while waiting, data returns two cycles later
    cycle();                                  // -> REQ at 0x44
    flush = 1; pc = 32'h200;
    cycle();
    flush = 0;
    check("fw_req_held", mem_req, 1);
    cycle();
    ack = 1; rdata = 32'hDEAD_BEEF;
    cycle();
    ack = 0;
    check("fw_no_valid", instr_valid, 0);
    check("fw_idle", mem_req, 0);
    cycle();
    check("fw_refetch_req", mem_req, 1);
    check("fw_refetch_addr", mem_addr, 32'h200);
    ack = 1; rdata = 32'hCAFE_0001;
    cycle();
    ack = 0;
    check("fw_refetch_out", instr_out, 32'hCAFE_0001);

    // Flush together with ready in HOLD
    flush = 1; ready = 1;
    cycle();
    flush = 0; ready = 0;
    check("fr_no_pc_en", pc_en, 0);
    check("fr_valid_low", instr_valid, 0);

    // Misaligned PC
    pc = 32'h102;
    cycle();
    check("mis_no_req", mem_req, 0);
    check("mis_valid", instr_valid, 1);
    check("mis_flag", instr_misaligned, 1);
    check("mis_pc", instr_pc, 32'h102);
    ready = 1;
    cycle();
    ready = 0;
    cycle();

    // Asynchronous reset in the middle of a request
    pc = 32'h80;
    cycle();
    cycle();
    check("ar_in_req", mem_req, 1);
    ack = 1;
    reset = 1'b0;
    #1;
    model_reset();
    check_reset_values("ar");
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    compare_all();
    cycle();                                  // stale ack seen in IDLE is ignored
    ack = 0;
    check("ar_stale_ack_valid", instr_valid, 0);
    check("ar_refetch_req", mem_req, 1);

    // Randomized traffic
    for (int i = 0; i < 3000; i++) begin
      ack   = e_fetching && ($urandom_range(0, 2) == 0);
      rdata = $urandom;
      ready = ($urandom_range(0, 1) == 1);
      flush = ($urandom_range(0, 9) == 0);
      if (flush) begin
        if ($urandom_range(0, 5) == 0) pc = $urandom;
        else pc = $urandom & 32'hFFFF_FFFC;
      end
      cycle();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
